fp_exp_align: RTL and testbench

Exponent-compare and mantissa-alignment controller for the 32-bit floating-point adder. It accepts two IEEE-754 single-precision operands, selects the operand with the larger exponent, and computes the exponent difference. It drives the 5-bit alignment down counter (Load/count) and shifts the smaller mantissa right one bit per cycle while the counter's zero flag is low. The aligned operands, with guard, round and sticky bits, feed the mantissa add/subtract stage.

---
 rtl/fp_align_pkg.sv | 33 +++
 rtl/fp_unpack.sv | 25 ++
 rtl/fp_exp_align.sv | 174 +++++++++++++++++
 tb/tb_fp_exp_align.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fp_align_pkg.sv
// Shared widths, FSM state type and alignment helpers for the FP adder
// exponent-compare / mantissa-alignment controller.
package fp_align_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned FRAC_W    = 23;
  localparam int unsigned MANT_W    = 24;  // {hidden, frac}
  localparam int unsigned ALIGN_W   = 27;  // {hidden, frac, G, R, S}
  localparam int unsigned MAX_ALIGN = 26;  // largest distance that still leaves a live bit
  localparam int unsigned CNT_W     = 5;   // alignment down-counter width
  localparam int unsigned WORD_W    = 1 + EXP_W + FRAC_W;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } align_state_e;

  // One unpacked operand as seen by the alignment datapath.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  eff_exp;
    logic [MANT_W-1:0] mant;
  } operand_t;

  // Single-bit right shift that folds the two lowest bits into the sticky position,
  // so no set bit shifted past R is ever lost.
  function automatic logic [ALIGN_W-1:0] shr_sticky(input logic [ALIGN_W-1:0] v);
    return {1'b0, v[ALIGN_W-1:2], v[1] | v[0]};
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single-precision unpacker: sign, effective exponent
// (denormals treated as exponent 1) and the implicit hidden bit.
module fp_unpack
  import fp_align_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic              sign_o,
  output logic [EXP_W-1:0]  eff_exp_o,
  output logic              hidden_o,
  output logic [FRAC_W-1:0] frac_o
);

  logic [EXP_W-1:0] exp_raw;

  assign sign_o  = word_i[WORD_W-1];
  assign exp_raw = word_i[WORD_W-2 -: EXP_W];
  assign frac_o  = word_i[FRAC_W-1:0];

  // Denormals share the scale of exponent 1 but have no hidden bit.
  always_comb begin
    hidden_o  = (exp_raw != '0);
    eff_exp_o = hidden_o ? exp_raw : EXP_W'(1);
  end

endmodule

// File: rtl/fp_exp_align.sv
// Exponent compare and mantissa alignment controller for the FP adder.
// Picks the operand with the larger effective exponent, loads the external
// 5-bit down counter with the alignment distance and shifts the smaller
// mantissa right one bit per cycle until the counter reports zero.
// Build option: define FP_ALIGN_STICKY_EN to keep G/R/S bits; otherwise the
// three low bits of mant_small stay zero (truncating alignment).
module fp_exp_align
  import fp_align_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [WORD_W-1:0]   A,
  input  logic [WORD_W-1:0]   B,
  input  logic                cnt_zero,
  output logic                Load,
  output logic [CNT_W-1:0]    count,
  output logic                Busy,
  output logic                Done,
  output logic [EXP_W-1:0]    exp_out,
  output logic                sign_big,
  output logic                sign_small,
  output logic [MANT_W-1:0]   mant_big,
  output logic [ALIGN_W-1:0]  mant_small
);

  localparam logic [EXP_W-1:0] MaxAlignE = EXP_W'(MAX_ALIGN);

  // Unpacked operands
  logic              a_sign, b_sign;
  logic [EXP_W-1:0]  a_eff, b_eff;
  logic              a_hidden, b_hidden;
  logic [FRAC_W-1:0] a_frac, b_frac;

  fp_unpack u_unpack_a (
    .word_i    (A),
    .sign_o    (a_sign),
    .eff_exp_o (a_eff),
    .hidden_o  (a_hidden),
    .frac_o    (a_frac)
  );

  fp_unpack u_unpack_b (
    .word_i    (B),
    .sign_o    (b_sign),
    .eff_exp_o (b_eff),
    .hidden_o  (b_hidden),
    .frac_o    (b_frac)
  );

  operand_t         op_a, op_b, op_big, op_small;
  logic             b_is_big;
  logic [EXP_W-1:0] diff;
  logic             diff_sat;

  // Select big/small; ties go to A, mantissas never take part in the choice.
  always_comb begin
    op_a     = '{sign: a_sign, eff_exp: a_eff, mant: {a_hidden, a_frac}};
    op_b     = '{sign: b_sign, eff_exp: b_eff, mant: {b_hidden, b_frac}};
    b_is_big = (b_eff > a_eff);
    op_big   = b_is_big ? op_b : op_a;
    op_small = b_is_big ? op_a : op_b;
    diff     = op_big.eff_exp - op_small.eff_exp;
    diff_sat = (diff > MaxAlignE);
  end

  // Registered state and datapath
  align_state_e       state_q, state_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic               sign_big_q, sign_big_d;
  logic               sign_small_q, sign_small_d;
  logic [MANT_W-1:0]  mant_big_q, mant_big_d;
  logic [ALIGN_W-1:0] mant_small_q, mant_small_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sat_q, sat_d;

  logic [ALIGN_W-1:0] mant_step;  // mant_small after one alignment shift
  logic [ALIGN_W-1:0] mant_sat;   // mant_small when the distance saturates

`ifdef FP_ALIGN_STICKY_EN
  assign mant_step = shr_sticky(mant_small_q);
  // Everything is shifted out; only the sticky summary of the mantissa survives.
  assign mant_sat  = {{(ALIGN_W-1){1'b0}}, |mant_small_q[ALIGN_W-1:3]};
`else
  // Low three bits are held at zero, so bit 3 simply falls off.
  assign mant_step = {1'b0, mant_small_q[ALIGN_W-1:4], 3'b000};
  assign mant_sat  = '0;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;
    count_d      = count_q;
    sat_d        = sat_q;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d      = StLoad;
          exp_d        = op_big.eff_exp;
          sign_big_d   = op_big.sign;
          sign_small_d = op_small.sign;
          mant_big_d   = op_big.mant;
          mant_small_d = {op_small.mant, 3'b000};
          sat_d        = diff_sat;
          count_d      = diff_sat ? '0 : diff[CNT_W-1:0];
        end
      end
      StLoad: begin
        // The counter captures count on this edge; saturation is resolved here
        // so SHIFT sees a zero count and exits immediately.
        state_d = StShift;
        if (sat_q) begin
          mant_small_d = mant_sat;
        end
      end
      StShift: begin
        if (cnt_zero) begin
          state_d = StDone;
        end else begin
          mant_small_d = mant_step;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      exp_q        <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      mant_big_q   <= '0;
      mant_small_q <= '0;
      count_q      <= '0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
      count_q      <= count_d;
      sat_q        <= sat_d;
    end
  end

  // Outputs decoded from registers only
  always_comb begin
    Load       = (state_q == StLoad);
    Busy       = (state_q != StIdle);
    Done       = (state_q == StDone);
    count      = count_q;
    exp_out    = exp_q;
    sign_big   = sign_big_q;
    sign_small = sign_small_q;
    mant_big   = mant_big_q;
    mant_small = mant_small_q;
  end

endmodule

// File: tb/tb_fp_exp_align.sv
// Directed bench for fp_exp_align with a behavioural model of the external
// 5-bit alignment down counter. Honours FP_ALIGN_STICKY_EN like the RTL.
`timescale 1ns/1ps
module tb_fp_exp_align;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [31:0] A, B;
  logic        cnt_zero;
  logic        Load;
  logic [4:0]  count;
  logic        Busy;
  logic        Done;
  logic [7:0]  exp_out;
  logic        sign_big, sign_small;
  logic [23:0] mant_big;
  logic [26:0] mant_small;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  fp_exp_align dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .A          (A),
    .B          (B),
    .cnt_zero   (cnt_zero),
    .Load       (Load),
    .count      (count),
    .Busy       (Busy),
    .Done       (Done),
    .exp_out    (exp_out),
    .sign_big   (sign_big),
    .sign_small (sign_small),
    .mant_big   (mant_big),
    .mant_small (mant_small)
  );

  // External down counter: loads on Load, otherwise decrements towards zero.
  logic [4:0] cnt_q;
  always @(posedge Clk) begin
    if (Reset)            cnt_q <= 5'd0;
    else if (Load)        cnt_q <= count;
    else if (cnt_q != 0)  cnt_q <= cnt_q - 5'd1;
  end
  assign cnt_zero = (cnt_q == 5'd0);

`ifdef FP_ALIGN_STICKY_EN
  localparam logic [26:0] MsDiff24 = 27'h0000005;
  localparam logic [26:0] MsSat    = 27'h0000001;
`else
  localparam logic [26:0] MsDiff24 = 27'h0000000;
  localparam logic [26:0] MsSat    = 27'h0000000;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  32'(Busy), 32'd0);
    check({tag, "_load"},  32'(Load), 32'd0);
    check({tag, "_done"},  32'(Done), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_exp"},   32'(exp_out), 32'd0);
    check({tag, "_signs"}, 32'({sign_big, sign_small}), 32'd0);
    check({tag, "_mbig"},  32'(mant_big), 32'd0);
    check({tag, "_msml"},  32'(mant_small), 32'd0);
  endtask

  // One transaction: Start accepted on the next posedge; n counts cycles after
  // that edge, LOAD being cycle 1. Optionally pulses Start again mid-SHIFT.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [4:0] cnt, input logic [7:0] ex,
                        input logic sb, input logic ss, input logic [23:0] mb,
                        input logic [26:0] ms, input bit pulse_mid);
    int n;
    @(negedge Clk);
    A = a; B = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    n = 1;
    check({tag, "_load"},  32'(Load), 32'd1);
    check({tag, "_count"}, 32'(count), 32'(cnt));
    check({tag, "_busy"},  32'(Busy), 32'd1);
    while (!Done && n < 64) begin
      @(negedge Clk);
      n++;
      Start = (pulse_mid && n == 3);
      if (pulse_mid && n == 3) begin A = 32'h4F800000; B = 32'h00000000; end
    end
    Start = 1'b0;
    check({tag, "_done_seen"}, 32'(Done), 32'd1);
    check({tag, "_latency"},   32'(n), 32'(lat));
    check({tag, "_exp"},       32'(exp_out), 32'(ex));
    check({tag, "_signs"},     32'({sign_big, sign_small}), 32'({sb, ss}));
    check({tag, "_mbig"},      32'(mant_big), 32'(mb));
    check({tag, "_msml"},      32'(mant_small), 32'(ms));
    @(negedge Clk);
    check({tag, "_done_pulse"}, 32'(Done), 32'd0);
    check({tag, "_idle"},       32'(Busy), 32'd0);
    check({tag, "_hold"},       32'(mant_small), 32'(ms));
  endtask

  initial begin
    int n;
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_idle_zero("reset");
    Reset = 1'b0;

    // diff 2
    run_op("diff2", 32'h3F800000, 32'h3E800000, 5, 5'd2, 8'h7F, 1'b0, 1'b0,
           24'h800000, 27'h1000000, 1'b0);
    // equal exponents, A wins the tie, no shifts
    run_op("diff0", 32'h40000000, 32'h40000000, 3, 5'd0, 8'h80, 1'b0, 1'b0,
           24'h800000, 27'h4000000, 1'b0);
    // diff 24, sticky collects the trailing 1
    run_op("diff24", 32'h4B800000, 32'h3F800001, 27, 5'd24, 8'h97, 1'b0, 1'b0,
           24'h800000, MsDiff24, 1'b0);
    // diff 32 saturates
    run_op("sat", 32'h4F800000, 32'h3F800000, 3, 5'd0, 8'h9F, 1'b0, 1'b0,
           24'h800000, MsSat, 1'b0);
    // B bigger, negative A; Start pulsed mid-SHIFT must be ignored
    run_op("bbig", 32'hBE800000, 32'h3F800000, 5, 5'd2, 8'h7F, 1'b0, 1'b1,
           24'h800000, 27'h1000000, 1'b1);
    @(negedge Clk);
    check("no_queue_busy", 32'(Busy), 32'd0);

    // Reset in the middle of a long SHIFT
    @(negedge Clk);
    A = 32'h4B800000; B = 32'h3F800001; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    n = 1;
    repeat (5) begin @(negedge Clk); n++; end
    check("mid_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_idle_zero("midrst");

    // Normal operation after the abort
    run_op("after_rst", 32'h3F800000, 32'h3E800000, 5, 5'd2, 8'h7F, 1'b0, 1'b0,
           24'h800000, 27'h1000000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
